// File: rtl/neuron_pkg.sv
// Shared types and arithmetic for the neuron update scheduler.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package neuron_pkg;

    localparam int WORD_W_DEF = 32;
    // Working width for saturating adds; covers any WORD_W up to 63 bits.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, WRITE} nus_state_t;

    // Signed add of two sign-extended w-bit values, clamped to the w-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        s  = a + b;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among N_REQ requesters, searching upward from ptr.
// Latency: purely combinational.
// Backpressure: none; gnt is zero when req is zero.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    // First active request at or after ptr, wrapping around.
    always_comb begin
        int   cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(ptr) + off) % N_REQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/neuron_update_scheduler.sv
// Arbitrates N synapse requesters onto one neuron RAM; each grant is a saturating read-modify-write.
// Latency: rden in the IDLE cycle, ack/spike RD_LAT+1 cycles later; one update per RD_LAT+2 cycles.
// Backpressure: req is level-held until ack; init has priority and waits for any update in flight.
module neuron_update_scheduler
    import neuron_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WORD_W = WORD_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init_start,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] weight,
    input  logic [WORD_W-1:0]       threshold,
    output logic [N_REQ-1:0]        grant,
    output logic                    ack,
    output logic                    spike,
    output logic                    busy,
    output logic                    ram_rden,
    output logic                    ram_wren,
    output logic                    ram_reset_val,
    output logic [WORD_W-1:0]       ram_data_in,
    input  logic [WORD_W-1:0]       ram_q
);

    localparam int IDX_W = $clog2(N_REQ);

    nus_state_t              state;
    logic [1:0]              lat_cnt;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        arb_idx;
    logic [N_REQ-1:0]        arb_gnt;
    logic [WORD_W-1:0]       w_q;
    logic                    init_pending;
    logic                    start_upd;
    logic signed [WORD_W-1:0] sum;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // The read is issued in the IDLE cycle that picks the winner, so the RAM
    // latency overlaps RD_WAIT and an update takes exactly RD_LAT+2 cycles.
    assign start_upd = (state == IDLE) && !init_pending && !init_start && (|req);
    assign ram_rden  = start_upd && !reset;

    // New potential, computed straight off the RAM output on the capture edge.
    assign sum = WORD_W'(sat_add(SAT_W'($signed(ram_q)), SAT_W'($signed(w_q)), WORD_W));

    // Scheduler FSM; every output except ram_rden is registered for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT;
            lat_cnt       <= '0;
            idx_q         <= '0;
            w_q           <= '0;
            init_pending  <= 1'b0;
            rr_ptr        <= '0;
            grant         <= '0;
            ack           <= 1'b0;
            spike         <= 1'b0;
            busy          <= 1'b0;
            ram_wren      <= 1'b0;
            ram_reset_val <= 1'b0;
            ram_data_in   <= '0;
        end else begin
            ack           <= 1'b0;
            spike         <= 1'b0;
            ram_wren      <= 1'b0;
            ram_reset_val <= 1'b0;
            ram_data_in   <= '0;
            if (init_start && (state != IDLE)) begin
                init_pending <= 1'b1;
            end
            case (state)
                INIT: begin
                    // busy low here means we just left reset and the INIT
                    // strobes have not been shown yet; show them for one cycle.
                    if (!busy) begin
                        ram_wren      <= 1'b1;
                        ram_reset_val <= 1'b1;
                        busy          <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (init_pending || init_start) begin
                        state         <= INIT;
                        init_pending  <= 1'b0;
                        ram_wren      <= 1'b1;
                        ram_reset_val <= 1'b1;
                        busy          <= 1'b1;
                    end else if (|req) begin
                        state   <= RD_WAIT;
                        idx_q   <= arb_idx;
                        w_q     <= weight[arb_idx*WORD_W +: WORD_W];
                        grant   <= arb_gnt;
                        busy    <= 1'b1;
                        lat_cnt <= '0;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 2'(RD_LAT - 1)) begin
                        state       <= WRITE;
                        ram_wren    <= 1'b1;
                        ack         <= 1'b1;
                        ram_data_in <= sum;
                        if (sum >= $signed(threshold)) begin
                            spike         <= 1'b1;
                            ram_reset_val <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    rr_ptr <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    grant  <= '0;
                    // A queued init goes straight in after the commit, ahead of any waiting request.
                    if (init_pending || init_start) begin
                        state         <= INIT;
                        init_pending  <= 1'b0;
                        ram_wren      <= 1'b1;
                        ram_reset_val <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Self-checking bench for neuron_update_scheduler with a behavioural RAM and reference model.
// Latency: checks rden-to-ack distance and back-to-back update spacing.
// Backpressure: requesters hold req until ack; init_start and reset are injected mid-update.
module tb_neuron_update_scheduler;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 32;
    localparam int RD_LAT = 2;
    localparam logic [31:0] INIT_VAL = 32'd7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         init_start = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] weight = '0;
    logic [31:0]  threshold = '0;
    logic [3:0]   grant;
    logic         ack, spike, busy, ram_rden, ram_wren, ram_reset_val;
    logic [31:0]  ram_data_in, ram_q;

    logic [31:0]  mem = '0;
    logic [31:0]  rd_p1 = '0;
    logic [31:0]  rd_p2 = '0;
    logic [31:0]  pre_val = '0;
    logic         pre_en = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           model_ptr = 0;
    int           cyc = 0;

    neuron_update_scheduler #(.N_REQ(N_REQ), .WORD_W(WORD_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .init_start(init_start), .req(req), .weight(weight),
        .threshold(threshold), .grant(grant), .ack(ack), .spike(spike), .busy(busy),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_reset_val(ram_reset_val),
        .ram_data_in(ram_data_in), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-word RAM: write/init path, read pipeline of RD_LAT=2 registers; junk when not read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) mem <= pre_val;
        else if (ram_wren) mem <= ram_reset_val ? INIT_VAL : ram_data_in;
        rd_p1 <= ram_rden ? mem : 32'hDEAD_BEEF;
        rd_p2 <= rd_p1;
    end
    assign ram_q = rd_p2;

    function automatic logic [31:0] ref_sat(input logic [31:0] a, input logic [31:0] b);
        longint t;
        t = longint'($signed(a)) + longint'($signed(b));
        if (t > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (t < -64'sd2147483648) return 32'h8000_0000;
        return t[31:0];
    endfunction

    function automatic int ref_pick(input logic [3:0] m, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (m[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; init_start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        tick();
        model_ptr = 0;
    endtask

    task automatic preload(input logic [31:0] v);
        pre_val = v; pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic set_w(input int slot, input logic [31:0] v);
        weight[slot*32 +: 32] = v;
    endtask

    // Called in an IDLE cycle with req driven; follows one update to its ack (bounded).
    task automatic observe_update(input logic drop, output int g, output int lat,
                                  output logic [31:0] din, output logic spk, output logic rv,
                                  output logic wr, output int nrden, output logic gstable,
                                  output logic overlap, output logic ok);
        logic [3:0] g0;
        #1;
        nrden = ram_rden ? 1 : 0;
        overlap = 1'b0; gstable = 1'b1; ok = 1'b0; g = -1; lat = 0;
        din = '0; spk = 1'b0; rv = 1'b0; wr = 1'b0; g0 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #2;
            if (ram_rden) nrden++;
            if (ram_rden && ram_wren) overlap = 1'b1;
            if (c == 1) begin
                g0 = grant;
                for (int b = 0; b < 4; b++) if (grant[b]) g = (g == -1) ? b : -2;
                if (drop) req = '0;
            end else if (grant !== g0) begin
                gstable = 1'b0;
            end
            if (ack === 1'b1) begin
                lat = c; din = ram_data_in; spk = spike; rv = ram_reset_val; wr = ram_wren; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({grant, ack, spike, busy, ram_rden, ram_wren, ram_reset_val, ram_data_in} !== '0) begin
            n_err++; $display("FAIL reset_outputs got %0h want 0", {grant, ack, spike, busy, ram_rden, ram_wren, ram_reset_val, ram_data_in}); end
        reset = 1'b0;
        tick();
        n_cmp++; if ({ram_wren, ram_reset_val, busy} !== 3'b111) begin
            n_err++; $display("FAIL init_strobes got %b want 111", {ram_wren, ram_reset_val, busy}); end
        n_cmp++; if ({grant, ack, spike, ram_rden, ram_data_in} !== '0) begin
            n_err++; $display("FAIL init_others got %0h want 0", {grant, ack, spike, ram_rden, ram_data_in}); end
        tick();
        n_cmp++; if ({grant, ack, spike, busy, ram_rden, ram_wren, ram_reset_val, ram_data_in} !== '0) begin
            n_err++; $display("FAIL idle_outputs got %0h want 0", {grant, ack, spike, busy, ram_rden, ram_wren, ram_reset_val, ram_data_in}); end
        n_cmp++; if (mem !== INIT_VAL) begin
            n_err++; $display("FAIL init_ram got %0h want %0h", mem, INIT_VAL); end
        model_ptr = 0;
    endtask

    task automatic test_single_update();
        int g, lat, nr; logic [31:0] din; logic spk, rv, wr, gs, ov, ok;
        preload(32'd10); set_w(1, 32'd5); threshold = 32'd100; req = 4'b0010;
        observe_update(1'b0, g, lat, din, spk, rv, wr, nr, gs, ov, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_ack_timeout got %b want 1", ok); end
        n_cmp++; if (g !== 1 || gs !== 1'b1) begin n_err++; $display("FAIL single_grant got %0d/%b want 1/1", g, gs); end
        n_cmp++; if (lat !== RD_LAT + 1) begin n_err++; $display("FAIL single_latency got %0d want %0d", lat, RD_LAT + 1); end
        n_cmp++; if (nr !== 1 || ov !== 1'b0) begin n_err++; $display("FAIL single_rden got %0d/%b want 1/0", nr, ov); end
        n_cmp++; if (din !== 32'd15) begin n_err++; $display("FAIL single_data got %0d want 15", din); end
        n_cmp++; if ({spk, rv, wr} !== 3'b001) begin n_err++; $display("FAIL single_flags got %b want 001", {spk, rv, wr}); end
        model_ptr = 2;
        req = '0;
        tick();
        n_cmp++; if ({grant, busy, ack, ram_data_in} !== '0) begin
            n_err++; $display("FAIL single_after got %0h want 0", {grant, busy, ack, ram_data_in}); end
    endtask

    task automatic test_spike_late_drop();
        int g, lat, nr; logic [31:0] din; logic spk, rv, wr, gs, ov, ok;
        preload(32'd95); set_w(2, 32'd10); threshold = 32'd100; req = 4'b0100;
        observe_update(1'b1, g, lat, din, spk, rv, wr, nr, gs, ov, ok);
        n_cmp++; if (ok !== 1'b1 || g !== 2) begin n_err++; $display("FAIL spike_ack got %b/%0d want 1/2", ok, g); end
        n_cmp++; if ({spk, rv, wr} !== 3'b111) begin n_err++; $display("FAIL spike_flags got %b want 111", {spk, rv, wr}); end
        n_cmp++; if (din !== 32'd105) begin n_err++; $display("FAIL spike_data got %0d want 105", din); end
        model_ptr = 3;
        tick();
        n_cmp++; if (mem !== INIT_VAL) begin n_err++; $display("FAIL spike_reload got %0h want %0h", mem, INIT_VAL); end
    endtask

    task automatic test_saturation();
        int g, lat, nr; logic [31:0] din; logic spk, rv, wr, gs, ov, ok;
        preload(32'h7FFF_FFF0); set_w(3, 32'h0000_0100); threshold = 32'h7FFF_FFFF; req = 4'b1000;
        observe_update(1'b0, g, lat, din, spk, rv, wr, nr, gs, ov, ok);
        n_cmp++; if (din !== ref_sat(32'h7FFF_FFF0, 32'h100) || spk !== 1'b1) begin
            n_err++; $display("FAIL sat_pos got %0h/%b want 7fffffff/1", din, spk); end
        req = '0; tick();
        preload(32'h8000_0010); set_w(0, 32'hFFFF_FF00); threshold = 32'd100; req = 4'b0001;
        observe_update(1'b0, g, lat, din, spk, rv, wr, nr, gs, ov, ok);
        n_cmp++; if (din !== 32'h8000_0000 || spk !== 1'b0 || g !== 0) begin
            n_err++; $display("FAIL sat_neg got %0h/%b/%0d want 80000000/0/0", din, spk, g); end
        model_ptr = 1;
        req = '0; tick();
    endtask

    task automatic test_fairness_back_to_back();
        int g, lat, nr, prev; logic [31:0] din; logic spk, rv, wr, gs, ov, ok;
        do_reset();
        preload(32'd0);
        for (int k = 0; k < 4; k++) set_w(k, 32'd1);
        threshold = 32'd1000; req = 4'b1111; prev = 0;
        for (int u = 0; u < 8; u++) begin
            observe_update(1'b0, g, lat, din, spk, rv, wr, nr, gs, ov, ok);
            n_cmp++; if (g !== u % 4 || din !== 32'(u + 1)) begin
                n_err++; $display("FAIL fair_%0d got %0d/%0d want %0d/%0d", u, g, din, u % 4, u + 1); end
            if (u > 0) begin
                n_cmp++; if (cyc - prev !== RD_LAT + 2) begin
                    n_err++; $display("FAIL b2b_gap_%0d got %0d want %0d", u, cyc - prev, RD_LAT + 2); end
            end
            prev = cyc;
            if (u < 7) tick();
        end
        req = '0; tick();
        model_ptr = 0;
    endtask

    task automatic test_init_during_rdwait();
        int first, second, g, lat, nr; logic [31:0] din; logic spk, rv, wr, gs, ov, ok;
        preload(32'd20); set_w(0, 32'd3); set_w(1, 32'd4); threshold = 32'd1000; req = 4'b0011;
        first = ref_pick(req, model_ptr);
        second = ref_pick(req & ~(4'b0001 << first), model_ptr);
        #1;
        n_cmp++; if (ram_rden !== 1'b1) begin n_err++; $display("FAIL init_q_rden got %b want 1", ram_rden); end
        tick(); init_start = 1'b1;
        tick(); init_start = 1'b0;
        tick();
        n_cmp++; if (ack !== 1'b1 || ram_data_in !== 32'd20 + weight[first*32 +: 32]) begin
            n_err++; $display("FAIL init_q_ack got %b/%0d want 1/%0d", ack, ram_data_in, 32'd20 + weight[first*32 +: 32]); end
        init_start = 1'b1; req = req & ~(4'b0001 << first);
        tick(); init_start = 1'b0;
        n_cmp++; if ({ram_wren, ram_reset_val, busy, ram_rden, ack, grant} !== {5'b11100, 4'b0000}) begin
            n_err++; $display("FAIL init_q_init got %b want 111000000", {ram_wren, ram_reset_val, busy, ram_rden, ack, grant}); end
        tick();
        n_cmp++; if ({ram_rden, ram_wren, busy} !== 3'b100) begin
            n_err++; $display("FAIL init_q_collapse got %b want 100", {ram_rden, ram_wren, busy}); end
        model_ptr = (first + 1) % 4;
        observe_update(1'b0, g, lat, din, spk, rv, wr, nr, gs, ov, ok);
        n_cmp++; if (g !== second || din !== INIT_VAL + weight[second*32 +: 32]) begin
            n_err++; $display("FAIL init_q_next got %0d/%0d want %0d/%0d", g, din, second, INIT_VAL + weight[second*32 +: 32]); end
        model_ptr = (second + 1) % 4;
        req = '0; tick();
    endtask

    task automatic test_random();
        logic [3:0] mask; logic [31:0] pot, s; logic [31:0] w [4]; logic es;
        int g, lat, nr, pick; logic [31:0] din; logic spk, rv, wr, gs, ov, ok;
        preload(32'd0); pot = 32'd0;
        mask = 4'($urandom_range(1, 15));
        for (int u = 0; u < 24; u++) begin
            for (int k = 0; k < 4; k++) begin
                w[k] = 32'($urandom_range(0, 70)) - 32'd30;
                set_w(k, w[k]);
            end
            threshold = 32'($urandom_range(20, 80));
            req = mask;
            pick = ref_pick(mask, model_ptr);
            s = ref_sat(pot, w[pick]);
            es = ($signed(s) >= $signed(threshold));
            observe_update(1'b0, g, lat, din, spk, rv, wr, nr, gs, ov, ok);
            n_cmp++; if (ok !== 1'b1 || g !== pick || lat !== RD_LAT + 1 || ov !== 1'b0) begin
                n_err++; $display("FAIL rnd_ctl_%0d got %b/%0d/%0d/%b want 1/%0d/%0d/0", u, ok, g, lat, ov, pick, RD_LAT + 1); end
            n_cmp++; if (din !== s || spk !== es || rv !== es) begin
                n_err++; $display("FAIL rnd_dat_%0d got %0h/%b/%b want %0h/%b/%b", u, din, spk, rv, s, es, es); end
            pot = es ? INIT_VAL : s;
            model_ptr = (pick + 1) % 4;
            mask = (mask & ~(4'b0001 << pick)) | 4'($urandom_range(0, 15));
            if (mask == 4'b0000) mask = 4'($urandom_range(1, 15));
            req = mask;
            tick();
        end
        req = '0; tick();
    endtask

    task automatic test_reset_mid_rdwait();
        int acks;
        preload(32'd50); set_w(0, 32'd1); req = 4'b0001; acks = 0;
        #1;
        tick();
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rst_mid_grant got %b want 0001", grant); end
        reset = 1'b1;
        tick();
        if (ack) acks++;
        n_cmp++; if ({grant, busy, ram_wren, ram_rden, spike} !== '0) begin
            n_err++; $display("FAIL rst_mid_clear got %0h want 0", {grant, busy, ram_wren, ram_rden, spike}); end
        tick();
        if (ack) acks++;
        reset = 1'b0;
        tick();
        if (ack) acks++;
        n_cmp++; if ({ram_wren, ram_reset_val, busy, grant} !== {3'b111, 4'b0000} || acks !== 0) begin
            n_err++; $display("FAIL rst_mid_init got %b/%0d want 1110000/0", {ram_wren, ram_reset_val, busy, grant}, acks); end
        req = '0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle got %b want 0", busy); end
        model_ptr = 0;
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_spike_late_drop();
        test_saturation();
        test_fairness_back_to_back();
        test_init_during_rdwait();
        test_random();
        test_reset_mid_rdwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
